// File: rtl/dst_axis_pack_if.sv
// Valid/ready stream bundle shared by the dst input side and the AXI4-Stream
// output side of dst_axis_pack. The producer of the beat uses the master
// modport and the consumer uses the slave modport.
interface dst_axis_pack_if #(
    parameter int W = 64
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;
    logic         last;

    // Beat producer: drives payload and valid, observes back-pressure
    modport master (
        output valid,
        output data,
        output last,
        input  ready
    );

    // Beat consumer: observes payload and valid, drives back-pressure
    modport slave (
        input  valid,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/dst_axis_pack.sv
// Downstream packer: takes the core's dst stream (two fp32 lanes per beat),
// buffers it in a DEPTH-entry first-word-fall-through FIFO and presents it as
// a 64-bit AXI4-Stream master toward the DMA S2MM port. The frame boundary
// (tlast) is the OR of the producer's marker and a beat counter compared to
// the programmed frame length; any disagreement raises a sticky error flag.
module dst_axis_pack #(
    parameter int DEPTH = 16,
    parameter int LEN_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic [LEN_W-1:0]   len_i,
    dst_axis_pack_if.slave     dst_s,
    dst_axis_pack_if.master    m_axis,
    output logic               frame_done_o,
    output logic               len_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = AW + 1;
    localparam logic [OW-1:0]    OCC_FULL = OW'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    // Each entry holds {last, lane1, lane0}
    localparam int EW = 65;

    // Storage array; no reset, emptiness is tracked by the occupancy count
    logic [EW-1:0]    mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q,    occ_d;
    logic [LEN_W-1:0] cnt_q,    cnt_d;
    logic             len_err_q, len_err_d;
    logic             frame_done_q, frame_done_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [EW-1:0]    head;
    logic             head_last;
    logic             len_en;
    logic             bnd;
    logic             out_valid;
    logic             out_last;
    logic [63:0]      out_data;

    // Status flags come from registered occupancy only, so dst_ready never
    // sees m_axis_tready and no dst_* -> m_axis_* combinational path exists
    always_comb begin
        fifo_full  = (occ_q == OCC_FULL);
        fifo_empty = (occ_q == '0);
    end

    // Handshake qualifiers
    always_comb begin
        push = dst_s.valid & ~fifo_full;
        pop  = ~fifo_empty & m_axis.ready;
    end

    // Write the incoming beat at the write pointer; a flush cycle drops it
    always_ff @(posedge clk) begin
        if (push && !clr_i) begin
            mem[wr_ptr_q] <= {dst_s.last, dst_s.data[63:32], dst_s.data[31:0]};
        end
    end

    // Head entry read straight from storage (first-word-fall-through)
    always_comb begin
        head      = mem[rd_ptr_q];
        head_last = head[EW-1];
    end

    // Frame-length boundary: the beat at position len-1 of the current frame
    always_comb begin
        len_en = (len_i != '0);
        bnd    = len_en & (cnt_q == (len_i - LEN_ONE));
    end

    // Output beat; payload forced to zero while empty so nothing stale leaks
    always_comb begin
        out_valid = ~fifo_empty;
        out_last  = out_valid & (head_last | bnd);
        out_data  = out_valid ? head[63:0] : 64'd0;
    end

    // Next-state for pointers, occupancy, beat counter and status flags;
    // a flush overrides any push or pop in the same cycle
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        cnt_d        = cnt_q;
        len_err_d    = len_err_q;
        frame_done_d = 1'b0;

        if (clr_i) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            occ_d        = '0;
            cnt_d        = '0;
            len_err_d    = 1'b0;
            frame_done_d = 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end

            unique case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase

            if (pop) begin
                // Counter restarts after every emitted frame end; with
                // len=0 it only restarts on producer markers and may wrap
                cnt_d        = out_last ? '0 : (cnt_q + 1'b1);
                frame_done_d = out_last;
                if (len_en && (head_last != bnd)) begin
                    len_err_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            cnt_q        <= '0;
            len_err_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            cnt_q        <= cnt_d;
            len_err_q    <= len_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Drive the two stream interfaces and the status outputs
    always_comb begin
        dst_s.ready   = ~fifo_full;
        m_axis.valid  = out_valid;
        m_axis.last   = out_last;
        m_axis.data   = out_data;
        frame_done_o  = frame_done_q;
        len_err_o     = len_err_q;
    end

endmodule

// File: tb/tb_dst_axis_pack.sv
// Directed bench for dst_axis_pack: frame boundary generation, fill/drain
// ordering, length mismatch detection, full-FIFO simultaneous pop/push,
// randomised valid/ready traffic and asynchronous/synchronous reset.
module tb_dst_axis_pack;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [11:0] len;
    logic        frame_done;
    logic        len_err;

    int n_checks;
    int n_fail;

    dst_axis_pack_if #(.W(64)) s_if ();
    dst_axis_pack_if #(.W(64)) m_if ();

    dst_axis_pack #(.DEPTH(16), .LEN_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (clr),
        .len_i        (len),
        .dst_s        (s_if),
        .m_axis       (m_if),
        .frame_done_o (frame_done),
        .len_err_o    (len_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Beat payload: lane0 low, lane1 high, both derived from the beat index
    function automatic logic [63:0] pat(input int unsigned idx);
        logic [31:0] a;
        logic [31:0] b;
        a = 32'h3F80_0000 ^ idx;
        b = 32'hC040_0000 + (idx * 32'd3);
        return {b, a};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_if.valid); end
        n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", s_if.ready); end
        n_checks++; if (m_if.last !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_if.last); end
        n_checks++; if (m_if.data !== 64'd0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_if.data); end
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %b want 0", len_err); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_tvalid: got %b want 0", m_if.valid); end
        $display("test_reset done");
    endtask

    task automatic test_frame_len4();
        len = 12'd4;
        m_if.ready = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_checks++; if (m_if.valid !== 1'b1) begin n_fail++; $display("FAIL f4_tvalid beat %0d: got %b want 1", k-1, m_if.valid); end
                n_checks++; if (m_if.data !== pat(k-1)) begin n_fail++; $display("FAIL f4_tdata beat %0d: got %h want %h", k-1, m_if.data, pat(k-1)); end
                n_checks++; if (m_if.last !== (k-1 == 3)) begin n_fail++; $display("FAIL f4_tlast beat %0d: got %b want %b", k-1, m_if.last, (k-1 == 3)); end
                n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL f4_frame_done_early beat %0d: got %b want 0", k-1, frame_done); end
            end
            s_if.valid = (k < 4);
            s_if.data  = pat(k);
            s_if.last  = (k == 3);
        end
        @(negedge clk);
        n_checks++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL f4_frame_done: got %b want 1", frame_done); end
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL f4_drained: got %b want 0", m_if.valid); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL f4_len_err: got %b want 0", len_err); end
        @(negedge clk);
        n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL f4_frame_done_pulse: got %b want 0", frame_done); end
        $display("test_frame_len4 done");
    endtask

    task automatic test_fill_drain();
        int in_idx;
        int out_idx;
        int cyc;
        in_idx  = 0;
        out_idx = 0;
        len = 12'd0;
        m_if.ready = 1'b0;
        s_if.last  = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready entry %0d: got %b want 1", c, s_if.ready); end
            s_if.valid = 1'b1;
            s_if.data  = pat(100 + in_idx);
            in_idx++;
        end
        @(negedge clk);
        s_if.data = pat(100 + in_idx);
        n_checks++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", s_if.ready); end
        n_checks++; if (m_if.valid !== 1'b1) begin n_fail++; $display("FAIL fill_full_tvalid: got %b want 1", m_if.valid); end
        @(negedge clk);
        n_checks++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL fill_still_full: got %b want 0", s_if.ready); end
        n_checks++; if (m_if.data !== pat(100)) begin n_fail++; $display("FAIL fill_head_stable: got %h want %h", m_if.data, pat(100)); end
        m_if.ready = 1'b1;
        cyc = 0;
        while (out_idx < 20 && cyc < 200) begin
            if (m_if.valid) begin
                n_checks++; if (m_if.data !== pat(100 + out_idx)) begin n_fail++; $display("FAIL drain_tdata beat %0d: got %h want %h", out_idx, m_if.data, pat(100 + out_idx)); end
                n_checks++; if (m_if.last !== 1'b0) begin n_fail++; $display("FAIL drain_tlast beat %0d: got %b want 0", out_idx, m_if.last); end
                out_idx++;
            end
            s_if.valid = (in_idx < 20);
            s_if.data  = pat(100 + in_idx);
            if (s_if.valid && s_if.ready) in_idx++;
            @(negedge clk);
            cyc++;
        end
        s_if.valid = 1'b0;
        n_checks++; if (out_idx != 20) begin n_fail++; $display("FAIL drain_timeout: got %0d beats want 20", out_idx); end
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", m_if.valid); end
        $display("test_fill_drain done");
    endtask

    task automatic test_len_mismatch();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        len = 12'd3;
        m_if.ready = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 4) begin
                n_checks++; if (m_if.data !== pat(50 + k - 1)) begin n_fail++; $display("FAIL mm_tdata beat %0d: got %h want %h", k-1, m_if.data, pat(50 + k - 1)); end
                n_checks++; if (m_if.last !== (k-1 >= 2)) begin n_fail++; $display("FAIL mm_tlast beat %0d: got %b want %b", k-1, m_if.last, (k-1 >= 2)); end
            end
            if (k >= 1) begin
                n_checks++; if (len_err !== (k >= 4)) begin n_fail++; $display("FAIL mm_len_err cycle %0d: got %b want %b", k, len_err, (k >= 4)); end
                n_checks++; if (frame_done !== (k == 4 || k == 5)) begin n_fail++; $display("FAIL mm_frame_done cycle %0d: got %b want %b", k, frame_done, (k == 4 || k == 5)); end
            end
            s_if.valid = (k < 4);
            s_if.data  = pat(50 + k);
            s_if.last  = (k == 3);
        end
        s_if.last = 1'b0;
        $display("test_len_mismatch done");
    endtask

    task automatic test_full_simul();
        len = 12'd0;
        m_if.ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            s_if.valid = 1'b1;
            s_if.data  = pat(200 + c);
        end
        @(negedge clk);
        n_checks++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL full_ready16: got %b want 0", s_if.ready); end
        m_if.ready = 1'b1;
        s_if.data  = pat(216);
        @(negedge clk);
        n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL full_ready15: got %b want 1", s_if.ready); end
        n_checks++; if (m_if.data !== pat(201)) begin n_fail++; $display("FAIL full_head_after_pop: got %h want %h", m_if.data, pat(201)); end
        m_if.ready = 1'b0;
        @(negedge clk);
        s_if.valid = 1'b0;
        n_checks++; if (s_if.ready !== 1'b0) begin n_fail++; $display("FAIL full_ready16_again: got %b want 0", s_if.ready); end
        m_if.ready = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            n_checks++; if (m_if.valid !== 1'b1 || m_if.data !== pat(200 + j)) begin n_fail++; $display("FAIL full_drain beat %0d: got %b/%h want 1/%h", j, m_if.valid, m_if.data, pat(200 + j)); end
            @(negedge clk);
        end
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL full_no_dup: got %b want 0", m_if.valid); end
        $display("test_full_simul done");
    endtask

    task automatic test_random();
        int in_idx;
        int out_idx;
        int cyc;
        bit prev_stall;
        logic [63:0] prev_data;
        logic prev_last;
        in_idx = 0;
        out_idx = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        len = 12'd0;
        while (out_idx < 1000 && cyc < 20000) begin
            n_checks++; if (m_if.valid !== (in_idx != out_idx)) begin n_fail++; $display("FAIL rnd_tvalid cycle %0d: got %b want %b", cyc, m_if.valid, (in_idx != out_idx)); end
            n_checks++; if (s_if.ready !== (in_idx - out_idx != 16)) begin n_fail++; $display("FAIL rnd_ready cycle %0d: got %b want %b", cyc, s_if.ready, (in_idx - out_idx != 16)); end
            if (m_if.valid) begin
                n_checks++; if (m_if.data !== pat(1000 + out_idx)) begin n_fail++; $display("FAIL rnd_tdata beat %0d: got %h want %h", out_idx, m_if.data, pat(1000 + out_idx)); end
                n_checks++; if (m_if.last !== (out_idx % 7 == 6)) begin n_fail++; $display("FAIL rnd_tlast beat %0d: got %b want %b", out_idx, m_if.last, (out_idx % 7 == 6)); end
                if (prev_stall) begin
                    n_checks++; if (m_if.data !== prev_data || m_if.last !== prev_last) begin n_fail++; $display("FAIL rnd_stall_hold beat %0d: got %h/%b want %h/%b", out_idx, m_if.data, m_if.last, prev_data, prev_last); end
                end
            end
            m_if.ready = 1'($urandom_range(0, 1));
            s_if.valid = (in_idx < 1000) && ($urandom_range(0, 1) == 1);
            s_if.data  = pat(1000 + in_idx);
            s_if.last  = (in_idx % 7 == 6);
            prev_stall = m_if.valid && !m_if.ready;
            prev_data  = m_if.data;
            prev_last  = m_if.last;
            if (m_if.valid && m_if.ready) out_idx++;
            if (s_if.valid && s_if.ready) in_idx++;
            @(negedge clk);
            cyc++;
        end
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
        n_checks++; if (out_idx != 1000) begin n_fail++; $display("FAIL rnd_timeout: got %0d beats want 1000", out_idx); end
        $display("test_random done: %0d beats in %0d cycles", out_idx, cyc);
    endtask

    task automatic test_rst_clr();
        len = 12'd0;
        m_if.ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            s_if.valid = 1'b1;
            s_if.data  = pat(300 + c);
        end
        @(negedge clk);
        n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL clr_err_before: got %b want 1", len_err); end
        clr = 1'b1;
        s_if.data = pat(305);
        #1;
        n_checks++; if (m_if.valid !== 1'b1) begin n_fail++; $display("FAIL clr_not_async: got %b want 1", m_if.valid); end
        @(posedge clk);
        #1;
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL clr_tvalid: got %b want 0", m_if.valid); end
        n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready: got %b want 1", s_if.ready); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL clr_len_err: got %b want 0", len_err); end
        @(negedge clk);
        clr = 1'b0;
        s_if.valid = 1'b0;
        @(negedge clk);
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL clr_push_dropped: got %b want 0", m_if.valid); end

        // len=1 with no producer marker: the single beat closes a frame by count
        len = 12'd1;
        m_if.ready = 1'b1;
        s_if.valid = 1'b1;
        s_if.data  = pat(310);
        @(negedge clk);
        s_if.valid = 1'b0;
        n_checks++; if (m_if.last !== 1'b1) begin n_fail++; $display("FAIL len1_tlast: got %b want 1", m_if.last); end
        @(negedge clk);
        n_checks++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL len1_len_err: got %b want 1", len_err); end

        m_if.ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            s_if.valid = 1'b1;
            s_if.data  = pat(320 + c);
            @(negedge clk);
        end
        s_if.valid = 1'b0;
        n_checks++; if (m_if.valid !== 1'b1) begin n_fail++; $display("FAIL pre_rst_tvalid: got %b want 1", m_if.valid); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL arst_tvalid: got %b want 0", m_if.valid); end
        n_checks++; if (s_if.ready !== 1'b1) begin n_fail++; $display("FAIL arst_ready: got %b want 1", s_if.ready); end
        n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL arst_len_err: got %b want 0", len_err); end
        n_checks++; if (m_if.data !== 64'd0 || m_if.last !== 1'b0) begin n_fail++; $display("FAIL arst_tdata: got %h/%b want 0/0", m_if.data, m_if.last); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (m_if.valid !== 1'b0) begin n_fail++; $display("FAIL arst_stays_empty: got %b want 0", m_if.valid); end
        $display("test_rst_clr done");
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b1;
        clr        = 1'b0;
        len        = 12'd0;
        s_if.valid = 1'b0;
        s_if.data  = 64'd0;
        s_if.last  = 1'b0;
        m_if.ready = 1'b0;

        test_reset();
        test_frame_len4();
        test_fill_drain();
        test_len_mismatch();
        test_full_simul();
        test_random();
        test_rst_clr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
